common_fifo_shift_mwmr: RTL

Synchronous shifting FIFO with a parametrised number of write and read lanes, for multi-issue front ends: fetch-to-decode buffers and writeback queues that push or pop several entries in one cycle. Storage is a register array with a fixed head at entry 0. Every pop shifts the surviving entries toward the head, and new entries are appended directly behind them. The block adds an occupancy count, per-lane ready/valid flags and a synchronous flush.

---
 rtl/common_fifo_shift_mwmr.sv | 97 +++++++++
 1 files changed

// File: rtl/common_fifo_shift_mwmr.sv
// Multi-lane shifting FIFO with the head fixed at entry 0: P pops and N pushes per cycle; pushed data is on dout after 1 edge.
// Backpressure: per-lane wready/dout_valid from registered count only; requests on unready/invalid lanes are dropped.
module common_fifo_shift_mwmr #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_WIDTH  = 32,
    parameter int FIFO_WPORTS = 2,
    parameter int FIFO_RPORTS = 2,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [FIFO_WPORTS*FIFO_WIDTH-1:0] din,
    input  logic [FIFO_WPORTS-1:0]            wen,
    output logic [FIFO_WPORTS-1:0]            wready,
    output logic [FIFO_RPORTS*FIFO_WIDTH-1:0] dout,
    output logic [FIFO_RPORTS-1:0]            dout_valid,
    input  logic [FIFO_RPORTS-1:0]            ren,
    output logic [CW-1:0]                     fifo_count,
    output logic                              fifo_empty,
    output logic                              fifo_full
);

    localparam int AW = CW + 1;

    logic [FIFO_WIDTH-1:0] mem     [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] mem_nxt [FIFO_DEPTH];
    logic [CW-1:0]         count;
    logic [AW-1:0]         pop_n;
    logic [AW-1:0]         push_n;
    logic [AW-1:0]         base;
    logic                  pop_run;
    logic                  push_run;

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));

    always_comb begin
        for (int k = 0; k < FIFO_RPORTS; k++) begin
            dout[k*FIFO_WIDTH +: FIFO_WIDTH] = mem[k];
            dout_valid[k] = AW'(count) > AW'(k);
        end
        for (int k = 0; k < FIFO_WPORTS; k++) begin
            wready[k] = (AW'(FIFO_DEPTH) - AW'(count)) > AW'(k);
        end
    end

    // Only the leading run of set request bits counts; the first gap ends it.
    always_comb begin
        pop_run  = 1'b1;
        pop_n    = '0;
        for (int k = 0; k < FIFO_RPORTS; k++) begin
            pop_run = pop_run & ren[k] & dout_valid[k];
            pop_n   = pop_n + AW'(pop_run);
        end
        push_run = 1'b1;
        push_n   = '0;
        for (int k = 0; k < FIFO_WPORTS; k++) begin
            push_run = push_run & wen[k] & wready[k];
            push_n   = push_n + AW'(push_run);
        end
    end

    // Survivors shift down by pop_n; new lanes land at base = count - pop_n.
    always_comb begin
        base = AW'(count) - pop_n;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_nxt[i] = mem[i];
            if (AW'(i) < base) begin
                for (int p = 1; p <= FIFO_RPORTS; p++) begin
                    if (pop_n == AW'(p) && (i + p) < FIFO_DEPTH)
                        mem_nxt[i] = mem[(i + p) % FIFO_DEPTH];
                end
            end else if (AW'(i) < base + push_n) begin
                for (int k = 0; k < FIFO_WPORTS; k++) begin
                    if (AW'(i) - base == AW'(k))
                        mem_nxt[i] = din[k*FIFO_WIDTH +: FIFO_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            count <= CW'(base + push_n);
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= mem_nxt[i];
        end
    end

endmodule
